countdown_ctrl: RTL and testbench
=================================

COUNTDOWN_CTRL -- requirements
Module: countdown_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_FREQ, default 1, tick rate in Hz; DIV = CLK_FREQ / TICK_FREQ (integer), legal only when DIV >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  level-sampled command: load/resume.
REQ-006 SHALL have port pause  input  1  level-sampled command: hold countdown.
REQ-007 SHALL have port clear  input  1  level-sampled command: abort to IDLE.
REQ-008 SHALL have port load_val  input  16  countdown start value in ticks, sampled on load.
REQ-009 SHALL have port count  output  16  current remaining ticks, registered.
REQ-010 SHALL have port tick  output  1  one-cycle strobe at each countdown decrement.
REQ-011 SHALL have port done  output  1  one-cycle strobe when count reaches 0.
REQ-012 SHALL have port state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-013 SHALL contain a prescaler counter 0..DIV-1 that advances only in RUN, holds in PAUSE, and is zeroed in IDLE and DONE.
REQ-014 SHALL assert tick for one cycle when prescaler equals DIV-1 in RUN, with the prescaler wrapping to 0 on that cycle; first tick occurs DIV cycles after entering RUN from IDLE.
REQ-015 SHALL decrement count by 1 on each tick; count SHALL never wrap below 0.
REQ-016 Command priority SHALL be clear > pause > start in every state.
REQ-017 IDLE: start with load_val != 0 -> count <= load_val, state RUN next cycle; start with load_val == 0 -> state DONE, done strobe on that transition.
REQ-018 RUN: tick with count == 1 -> count 0, state DONE, done strobe in the same cycle as tick; pause -> PAUSE next cycle.
REQ-019 RUN: tick coincident with pause SHALL still apply the decrement (and done, if count == 1; DONE wins over PAUSE).
REQ-020 PAUSE: start -> RUN next cycle, count and prescaler unchanged (resume, not reload); no tick in PAUSE.
REQ-021 DONE: count holds 0; start -> reload load_val and RUN (same rules as REQ-017); pause ignored.
REQ-022 clear in any state -> IDLE, count 0, prescaler 0 next cycle; a tick due on that cycle SHALL be suppressed.
REQ-023 start held high SHALL NOT reload while in RUN; start is ignored in RUN.

Reset
REQ-024 rst SHALL dominate all commands; on the cycle after rst high: state IDLE, count 0, prescaler 0, tick 0, done 0.
REQ-025 rst asserted mid-countdown SHALL discard the countdown with no done strobe.

Configuration
REQ-026 Macro COUNTDOWN_CTRL_AUTORELOAD_EN SHALL select the terminal behaviour.
REQ-027 With the macro defined: the tick that takes count 1->0 SHALL strobe done, reload count <= load_val, and remain in RUN; if load_val == 0 at that moment, go to DONE.
REQ-028 Without the macro: behaviour per REQ-018/REQ-021 (stop in DONE).

Verification (CLK_FREQ=8, TICK_FREQ=2, DIV=4)
REQ-029 rst 1 cycle, then idle -> state 0, count 0, tick/done 0.
REQ-030 load_val=3, start 1 cycle -> RUN; ticks at 4, 8, 12 cycles after RUN entry; count 3->2->1->0; done with third tick; state DONE.
REQ-031 load_val=5, start, pause after 6 RUN cycles for 10 cycles, then start -> count 4 throughout PAUSE; next tick 2 cycles after resume; count 3.
REQ-032 load_val=2, clear asserted on the cycle a tick is due -> no tick, state IDLE, count 0.
REQ-033 load_val=0, start -> state DONE, done strobe once, tick never asserted.
REQ-034 COUNTDOWN_CTRL_AUTORELOAD_EN defined, load_val=2 -> done every 8 cycles, count sequence 2,1,2,1,..., state stays RUN.

Source files
------------

// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
//   Tick-based countdown timer with start / pause / clear commands.
//   A prescaler divides clk by DIV = CLK_FREQ / TICK_FREQ (DIV must be >= 2).
//   Each prescaler wrap in RUN produces a tick that decrements count.
//   When count reaches zero the controller strobes done and stops in DONE.
//
// Configuration macro:
//   COUNTDOWN_CTRL_AUTORELOAD_EN - when defined, the terminal tick strobes
//   done, reloads load_val and stays in RUN. If load_val is zero at that
//   moment, the controller goes to DONE instead.
//
// Ports:
//   clk       in   1   single clock, rising edge
//   rst       in   1   synchronous active-high reset, dominates all commands
//   start     in   1   load (IDLE/DONE) or resume (PAUSE); ignored in RUN
//   pause     in   1   hold the countdown (RUN -> PAUSE)
//   clear     in   1   abort to IDLE, count and prescaler zeroed
//   load_val  in   16  countdown start value in ticks
//   count     out  16  remaining ticks (registered)
//   tick      out  1   one-cycle strobe per decrement (registered)
//   done      out  1   one-cycle strobe when count reaches 0 (registered)
//   state     out  2   IDLE=0, RUN=1, PAUSE=2, DONE=3 (registered)
// -----------------------------------------------------------------------------
module countdown_ctrl #(
  parameter int CLK_FREQ  = 50000000,
  parameter int TICK_FREQ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        tick,
  output logic        done,
  output logic [1:0]  state
);

  localparam int DIV = CLK_FREQ / TICK_FREQ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_r;
  logic [15:0]   count_r;
  logic [PW-1:0] presc_r;
  logic          tick_r;
  logic          done_r;
  logic          tick_due_s;

  // A tick is due on the edge where the prescaler sits at its last value in RUN.
  assign tick_due_s = (state_r == RUN) && (presc_r == PRESC_LAST);

  // Controller FSM with prescaler, counter and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      count_r <= 16'd0;
      presc_r <= PRESC_ZERO;
      tick_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      tick_r <= 1'b0;
      done_r <= 1'b0;
      if (clear) begin
        // Highest priority: abort, and any tick due this cycle is dropped.
        state_r <= IDLE;
        count_r <= 16'd0;
        presc_r <= PRESC_ZERO;
      end else begin
        case (state_r)
          IDLE, DONE: begin
            presc_r <= PRESC_ZERO;
            // pause outranks start, so a simultaneous pause blocks the load.
            if (start && !pause) begin
              if (load_val != 16'd0) begin
                count_r <= load_val;
                state_r <= RUN;
              end else begin
                count_r <= 16'd0;
                state_r <= DONE;
                done_r  <= 1'b1;
              end
            end else begin
              count_r <= 16'd0;
              state_r <= state_r;
            end
          end

          RUN: begin
            if (tick_due_s) begin
              // The decrement is applied even when pause arrives on this edge.
              presc_r <= PRESC_ZERO;
              tick_r  <= 1'b1;
              if (count_r == 16'd1) begin
                done_r <= 1'b1;
`ifdef COUNTDOWN_CTRL_AUTORELOAD_EN
                if (load_val != 16'd0) begin
                  count_r <= load_val;
                  state_r <= pause ? PAUSE : RUN;
                end else begin
                  count_r <= 16'd0;
                  state_r <= DONE;
                end
`else
                // Terminal tick: DONE wins over a coincident pause.
                count_r <= 16'd0;
                state_r <= DONE;
`endif
              end else if (count_r != 16'd0) begin
                count_r <= count_r - 16'd1;
                state_r <= pause ? PAUSE : RUN;
              end else begin
                // Count never wraps below zero.
                count_r <= 16'd0;
                state_r <= DONE;
              end
            end else begin
              presc_r <= presc_r + PRESC_ONE;
              count_r <= count_r;
              state_r <= pause ? PAUSE : RUN;
            end
          end

          PAUSE: begin
            // Resume keeps count and prescaler exactly where they were.
            presc_r <= presc_r;
            count_r <= count_r;
            if (start && !pause) begin
              state_r <= RUN;
            end else begin
              state_r <= PAUSE;
            end
          end

          default: begin
            state_r <= IDLE;
            count_r <= 16'd0;
            presc_r <= PRESC_ZERO;
          end
        endcase
      end
    end
  end

  assign count = count_r;
  assign tick  = tick_r;
  assign done  = done_r;
  assign state = state_r;

endmodule

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
//   Directed bench for countdown_ctrl with CLK_FREQ=8, TICK_FREQ=2 (DIV=4).
//   Stimulus pushes expected (cycle, tick, done, count, state) records into a
//   queue; a monitor on the falling edge pops the records due on that cycle
//   and compares them, and flags any tick/done strobe nobody expected.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic        clk;
  logic        rst;
  logic        start;
  logic        pause;
  logic        clear;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        tick;
  logic        done;
  logic [1:0]  state;

  countdown_ctrl #(.CLK_FREQ(8), .TICK_FREQ(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .load_val (load_val),
    .count    (count),
    .tick     (tick),
    .done     (done),
    .state    (state)
  );

  typedef struct {
    int          c;
    logic        t;
    logic        d;
    logic [15:0] cnt;
    logic [1:0]  st;
    int          scen;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   scen = 0;
  int   compared = 0;
  int   mismatched = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: cyc is the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Expected values after rising edge number c.
  function automatic void expect_at(int c, logic t, logic d, logic [15:0] cnt, logic [1:0] st);
    exp_t e;
    e.c = c; e.t = t; e.d = d; e.cnt = cnt; e.st = st; e.scen = scen;
    q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare due records and catch unexpected strobes.
  always @(negedge clk) begin
    bit seen;
    seen = 1'b0;
    while (q.size() > 0 && q[0].c <= cyc) begin
      exp_t e;
      e = q.pop_front();
      compared = compared + 1;
      if (e.c < cyc) begin
        mismatched = mismatched + 1;
        $display("FAIL stale_record scen%0d: record for cyc%0d reached at cyc%0d, required on time",
                 e.scen, e.c, cyc);
      end else begin
        seen = 1'b1;
        if (tick !== e.t || done !== e.d || count !== e.cnt || state !== e.st) begin
          mismatched = mismatched + 1;
          $display("FAIL outputs scen%0d cyc%0d: got tick=%b done=%b count=%0d state=%0d, required tick=%b done=%b count=%0d state=%0d",
                   e.scen, cyc, tick, done, count, state, e.t, e.d, e.cnt, e.st);
        end
      end
    end
    if (!seen && (tick !== 1'b0 || done !== 1'b0)) begin
      compared = compared + 1;
      mismatched = mismatched + 1;
      $display("FAIL unexpected_strobe scen%0d cyc%0d: got tick=%b done=%b count=%0d state=%0d, required no strobe",
               scen, cyc, tick, done, count, state);
    end
  end

  initial begin
    int e;
    int r;
    rst = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0; load_val = 16'd0;

    // Reset, then idle.
    scen = 1;
    expect_at(cyc + 1, 1'b0, 1'b0, 16'd0, S_IDLE);
    expect_at(cyc + 3, 1'b0, 1'b0, 16'd0, S_IDLE);
    step();
    rst = 1'b0;
    repeat (2) step();

`ifndef COUNTDOWN_CTRL_AUTORELOAD_EN
    // load 3: ticks at 4/8/12 cycles after RUN entry, done with the third.
    scen = 2;
    e = cyc + 1;
    expect_at(e,      1'b0, 1'b0, 16'd3, S_RUN);
    expect_at(e + 4,  1'b1, 1'b0, 16'd2, S_RUN);
    expect_at(e + 8,  1'b1, 1'b0, 16'd1, S_RUN);
    expect_at(e + 12, 1'b1, 1'b1, 16'd0, S_DONE);
    expect_at(e + 13, 1'b0, 1'b0, 16'd0, S_DONE);
    load_val = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (13) step();

    // load 5 from DONE, pause after 6 RUN cycles, resume, start held in RUN, clear.
    scen = 3;
    e = cyc + 1;
    expect_at(e,      1'b0, 1'b0, 16'd5, S_RUN);
    expect_at(e + 4,  1'b1, 1'b0, 16'd4, S_RUN);
    expect_at(e + 6,  1'b0, 1'b0, 16'd4, S_PAUSE);
    expect_at(e + 10, 1'b0, 1'b0, 16'd4, S_PAUSE);
    expect_at(e + 15, 1'b0, 1'b0, 16'd4, S_PAUSE);
    expect_at(e + 16, 1'b0, 1'b0, 16'd4, S_RUN);
    expect_at(e + 18, 1'b1, 1'b0, 16'd3, S_RUN);
    expect_at(e + 19, 1'b0, 1'b0, 16'd0, S_IDLE);
    load_val = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    pause = 1'b1;
    repeat (6) step();
    start = 1'b1;
    repeat (4) step();
    pause = 1'b0;
    repeat (3) step();
    clear = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    repeat (2) step();
`endif

    // load 2, clear on the edge where a tick is due: no tick, IDLE.
    scen = 4;
    e = cyc + 1;
    expect_at(e,     1'b0, 1'b0, 16'd2, S_RUN);
    expect_at(e + 3, 1'b0, 1'b0, 16'd2, S_RUN);
    expect_at(e + 4, 1'b0, 1'b0, 16'd0, S_IDLE);
    expect_at(e + 8, 1'b0, 1'b0, 16'd0, S_IDLE);
    load_val = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    repeat (4) step();

    // load 0: straight to DONE with a single done strobe, no tick.
    scen = 5;
    e = cyc + 1;
    expect_at(e,     1'b0, 1'b1, 16'd0, S_DONE);
    expect_at(e + 1, 1'b0, 1'b0, 16'd0, S_DONE);
    expect_at(e + 5, 1'b0, 1'b0, 16'd0, S_DONE);
    load_val = 16'd0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();

`ifndef COUNTDOWN_CTRL_AUTORELOAD_EN
    // DONE: pause blocks start; then reload; rst on a tick-due edge drops it.
    scen = 6;
    e = cyc + 1;
    r = e + 1;
    expect_at(e,      1'b0, 1'b0, 16'd0, S_DONE);
    expect_at(r,      1'b0, 1'b0, 16'd3, S_RUN);
    expect_at(r + 4,  1'b1, 1'b0, 16'd2, S_RUN);
    expect_at(r + 8,  1'b0, 1'b0, 16'd0, S_IDLE);
    expect_at(r + 12, 1'b0, 1'b0, 16'd0, S_IDLE);
    load_val = 16'd3; pause = 1'b1; start = 1'b1;
    step();
    pause = 1'b0;
    step();
    start = 1'b0;
    repeat (7) step();
    rst = 1'b1; start = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    repeat (4) step();

    // Tick coincident with pause: decrement applies; at count 1 DONE wins.
    scen = 7;
    e = cyc + 1;
    expect_at(e,      1'b0, 1'b0, 16'd3, S_RUN);
    expect_at(e + 4,  1'b1, 1'b0, 16'd2, S_PAUSE);
    expect_at(e + 5,  1'b0, 1'b0, 16'd2, S_RUN);
    expect_at(e + 9,  1'b1, 1'b0, 16'd1, S_RUN);
    expect_at(e + 13, 1'b1, 1'b1, 16'd0, S_DONE);
    expect_at(e + 14, 1'b0, 1'b0, 16'd0, S_DONE);
    load_val = 16'd3; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    pause = 1'b1;
    step();
    pause = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    pause = 1'b1;
    repeat (2) step();
    pause = 1'b0;
`else
    // Auto-reload: done every 8 cycles, count 2,1,2,1..., stop when load_val is 0.
    scen = 8;
    e = cyc + 1;
    expect_at(e,      1'b0, 1'b0, 16'd2, S_RUN);
    expect_at(e + 4,  1'b1, 1'b0, 16'd1, S_RUN);
    expect_at(e + 8,  1'b1, 1'b1, 16'd2, S_RUN);
    expect_at(e + 12, 1'b1, 1'b0, 16'd1, S_RUN);
    expect_at(e + 16, 1'b1, 1'b1, 16'd2, S_RUN);
    expect_at(e + 20, 1'b1, 1'b0, 16'd1, S_RUN);
    expect_at(e + 24, 1'b1, 1'b1, 16'd0, S_DONE);
    expect_at(e + 25, 1'b0, 1'b0, 16'd0, S_DONE);
    load_val = 16'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (23) step();
    load_val = 16'd0;
    repeat (2) step();
`endif

    repeat (3) step();
    compared = compared + 1;
    if (q.size() != 0) begin
      mismatched = mismatched + 1;
      $display("FAIL drain: got %0d unchecked records, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
